// File: rtl/aes_round_ctrl.sv
// -----------------------------------------------------------------------------
// aes_round_ctrl
//
// Iterative AES encryption round controller. The S-box / ShiftRows /
// MixColumns / AddRoundKey logic and the key schedule live outside this
// block. The controller sequences them one round per clock:
//
//   accept edge : state <= in_data ^ round_key[0]            (initial AddRoundKey)
//   rounds 1..NR: state <= dp_result, using round_key[rnd]   (dp_last on round NR)
//   DONE        : ciphertext held on out_data until out_ready
//
// Ports
//   clk        in   1    single clock; all state changes on its rising edge
//   rst_n      in   1    synchronous active-low reset
//   in_valid   in   1    plaintext block offered
//   in_ready   out  1    block can be accepted this cycle
//   in_data    in   128  plaintext, byte 0 in [127:120]
//   rk_idx     out  4    round-key index requested from the key schedule
//   round_key  in   128  key for rk_idx, valid in the same cycle
//   dp_state   out  128  current state, to the external round datapath
//   dp_last    out  1    final round: datapath bypasses MixColumns
//   dp_result  in   128  combinational round result for dp_state/round_key
//   out_valid  out  1    ciphertext available
//   out_ready  in   1    consumer accepts the ciphertext
//   out_data   out  128  ciphertext (registered)
//   busy       out  1    high in any state other than IDLE
//   blk_cnt    out  32   completed-block counter, present only when the
//                        macro AES_ROUND_CTRL_PERF_CNT_EN is defined
//
// Parameter
//   NR         number of AES rounds: 10, 12 or 14 (AES-128/192/256)
//
// Configuration macro
//   AES_ROUND_CTRL_PERF_CNT_EN  adds the blk_cnt output and its counter.
// -----------------------------------------------------------------------------
module aes_round_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   rk_idx,
    input  logic [127:0] round_key,
    output logic [127:0] dp_state,
    output logic         dp_last,
    input  logic [127:0] dp_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
`ifdef AES_ROUND_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]  blk_cnt
`endif
);

    // Only the three AES key sizes have a defined round count.
    if (NR != 10 && NR != 12 && NR != 14) begin : g_nr_illegal
        $error("aes_round_ctrl: NR must be 10, 12 or 14");
    end

    localparam logic [3:0] NR_L = 4'(NR);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ROUND = 2'b01,
        DONE  = 2'b10
    } state_e;

    state_e       state_q, state_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] data_q, data_d;
    logic         out_valid_q, out_valid_d;
    logic         dp_last_q, dp_last_d;
    logic         accept;

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    // in_ready is the one combinational output: accepting in DONE depends on
    // out_ready in the same cycle so back-to-back blocks lose no cycle.
    // Gating with rst_n keeps the producer from seeing a handshake that the
    // reset is about to discard.
    assign in_ready = rst_n
                      && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign accept   = in_valid && in_ready;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        rnd_d       = rnd_q;
        data_d      = data_q;
        out_valid_d = out_valid_q;
        dp_last_d   = dp_last_q;

        case (state_q)
            IDLE: begin
                out_valid_d = 1'b0;
                dp_last_d   = 1'b0;
                if (accept) begin
                    data_d  = in_data ^ round_key;
                    rnd_d   = 4'd1;
                    state_d = ROUND;
                end
            end

            ROUND: begin
                data_d = dp_result;
                // >= rather than == so a corrupted counter still terminates
                // and rnd can never run past NR.
                if (rnd_q >= NR_L) begin
                    rnd_d       = 4'd0;
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    dp_last_d   = 1'b0;
                end else begin
                    rnd_d     = rnd_q + 4'd1;
                    // Registered so dp_last is high exactly while rnd == NR.
                    dp_last_d = ((rnd_q + 4'd1) == NR_L);
                end
            end

            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                    // A new block on the handshake edge is loaded exactly as
                    // from IDLE; rnd is already 0 so round_key is key 0.
                    if (accept) begin
                        data_d  = in_data ^ round_key;
                        rnd_d   = 4'd1;
                        state_d = ROUND;
                    end
                end
            end

            default: begin
                // Unreachable encoding: recover to a clean IDLE.
                state_d     = IDLE;
                rnd_d       = 4'd0;
                out_valid_d = 1'b0;
                dp_last_d   = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rnd_q       <= 4'd0;
            // NOTE: the state register is reset even though it is datapath,
            // because out_data must read zero after reset.
            data_q      <= '0;
            out_valid_q <= 1'b0;
            dp_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            data_q      <= data_d;
            out_valid_q <= out_valid_d;
            dp_last_q   <= dp_last_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // rnd is cleared on the way into DONE and IDLE, so it doubles as the
    // round-key index in every state.
    assign rk_idx    = rnd_q;
    assign dp_state  = data_q;
    assign dp_last   = dp_last_q;
    assign out_valid = out_valid_q;
    assign out_data  = data_q;
    assign busy      = (state_q != IDLE);

    // -------------------------------------------------------------------------
    // Optional completed-block counter
    // -------------------------------------------------------------------------
`ifdef AES_ROUND_CTRL_PERF_CNT_EN
    logic [31:0] blk_cnt_q;

    // Counts output handshakes; wraps naturally from 0xFFFFFFFF to 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blk_cnt_q <= '0;
        end else if (out_valid_q && out_ready) begin
            blk_cnt_q <= blk_cnt_q + 32'd1;
        end
    end

    assign blk_cnt = blk_cnt_q;
`endif

    // -------------------------------------------------------------------------
    // Properties
    // -------------------------------------------------------------------------
    a_rnd_bound : assert property (@(posedge clk) disable iff (!rst_n)
        rnd_q <= NR_L);

    a_out_hold : assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid_q && !out_ready) |=> (out_valid_q && $stable(data_q)));

endmodule
